// File: rtl/lpm_reg_pkg.sv
// Shared constants for the LPM table register controller: register map,
// STATUS/CMD bit positions and FSM state encoding.
package lpm_reg_pkg;

   localparam logic [2:0] REG_IP       = 3'd0;
   localparam logic [2:0] REG_MASK     = 3'd1;
   localparam logic [2:0] REG_NEXT_HOP = 3'd2;
   localparam logic [2:0] REG_OQ       = 3'd3;
   localparam logic [2:0] REG_ADDR     = 3'd4;
   localparam logic [2:0] REG_CMD      = 3'd5;
   localparam logic [2:0] REG_STATUS   = 3'd6;
   localparam logic [2:0] REG_WR_COUNT = 3'd7;

   localparam int STS_TIMEOUT = 1;
   localparam int STS_VERIFY  = 2;
   localparam int STS_ADDR    = 3;

   localparam int CMD_WR = 0;
   localparam int CMD_RD = 1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WR_WAIT   = 3'd1;
   localparam logic [2:0] ST_RD_WAIT   = 3'd2;
   localparam logic [2:0] ST_VRFY_WAIT = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;

endpackage

// File: rtl/lpm_req_timer.sv
// Wait-cycle counter for an outstanding lpm request; clear reloads zero,
// and the count holds once it reaches TIMEOUT_CYCLES-1 (expired).
module lpm_req_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && !expired)
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/lpm_table_reg_ctrl.sv
// Host register file that launches LPM route-table writes/reads and waits for acks.
// Optional macro LPM_WRITE_VERIFY_EN adds a read-back check after every table write.
module lpm_table_reg_ctrl
   import lpm_reg_pkg::*;
#(
   parameter int NUM_QUEUES     = 5,
   parameter int LUT_DEPTH      = 32,
   parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reg_req,
   input  logic                      reg_rd_wr_L,
   input  logic [2:0]                reg_addr,
   input  logic [31:0]               reg_wr_data,
   output logic                      reg_ack,
   output logic [31:0]               reg_rd_data,
   output logic                      lpm_wr_req,
   output logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
   output logic [31:0]               lpm_wr_ip,
   output logic [31:0]               lpm_wr_mask,
   output logic [31:0]               lpm_wr_next_hop_ip,
   output logic [NUM_QUEUES-1:0]     lpm_wr_oq,
   input  logic                      lpm_wr_ack,
   output logic                      lpm_rd_req,
   output logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
   input  logic [31:0]               lpm_rd_ip,
   input  logic [31:0]               lpm_rd_mask,
   input  logic [31:0]               lpm_rd_next_hop_ip,
   input  logic [NUM_QUEUES-1:0]     lpm_rd_oq,
   input  logic                      lpm_rd_ack
);

   logic [2:0]                state_q, state_d;
   logic [31:0]               ip_q, ip_d, mask_q, mask_d, nh_q, nh_d;
   logic [NUM_QUEUES-1:0]     oq_q, oq_d;
   logic [31:0]               addr_q, addr_d;
   logic                      tmo_err_q, tmo_err_d, addr_err_q, addr_err_d;
   logic [31:0]               wr_count_q, wr_count_d;
   logic                      reg_ack_q, reg_ack_d;
   logic [31:0]               reg_rd_data_q, reg_rd_data_d;
   logic                      wr_req_q, wr_req_d, rd_req_q, rd_req_d;
   logic [LUT_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [31:0]               wr_ip_q, wr_ip_d, wr_mask_q, wr_mask_d, wr_nh_q, wr_nh_d;
   logic [NUM_QUEUES-1:0]     wr_oq_q, wr_oq_d;
   logic [31:0]               rd_mux;
   logic                      timer_clr, timer_en, timer_expired;
`ifdef LPM_WRITE_VERIFY_EN
   logic                      vm_err_q, vm_err_d;
`else
   logic                      vm_err_q;
   assign vm_err_q = 1'b0;
`endif

   lpm_req_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         REG_IP:       rd_mux = ip_q;
         REG_MASK:     rd_mux = mask_q;
         REG_NEXT_HOP: rd_mux = nh_q;
         REG_OQ:       rd_mux[NUM_QUEUES-1:0] = oq_q;
         REG_ADDR:     rd_mux[LUT_DEPTH_BITS-1:0] = addr_q[LUT_DEPTH_BITS-1:0];
         REG_STATUS: begin
            rd_mux[STS_TIMEOUT] = tmo_err_q;
            rd_mux[STS_VERIFY]  = vm_err_q;
            rd_mux[STS_ADDR]    = addr_err_q;
         end
         REG_WR_COUNT: rd_mux = wr_count_q;
         default:      rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      ip_d          = ip_q;
      mask_d        = mask_q;
      nh_d          = nh_q;
      oq_d          = oq_q;
      addr_d        = addr_q;
      tmo_err_d     = tmo_err_q;
      addr_err_d    = addr_err_q;
      wr_count_d    = wr_count_q;
      reg_ack_d     = 1'b0;
      reg_rd_data_d = '0;
      wr_req_d      = wr_req_q;
      wr_addr_d     = wr_addr_q;
      wr_ip_d       = wr_ip_q;
      wr_mask_d     = wr_mask_q;
      wr_nh_d       = wr_nh_q;
      wr_oq_d       = wr_oq_q;
      rd_req_d      = rd_req_q;
      rd_addr_d     = rd_addr_q;
      timer_clr     = 1'b0;
      timer_en      = 1'b0;
`ifdef LPM_WRITE_VERIFY_EN
      vm_err_d      = vm_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (reg_req) begin
               // Every access acks through ST_ACK unless it launches an lpm request.
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
               if (reg_rd_wr_L) begin
                  reg_rd_data_d = rd_mux;
               end else begin
                  case (reg_addr)
                     REG_IP:       ip_d   = reg_wr_data;
                     REG_MASK:     mask_d = reg_wr_data;
                     REG_NEXT_HOP: nh_d   = reg_wr_data;
                     REG_OQ:       oq_d   = reg_wr_data[NUM_QUEUES-1:0];
                     REG_ADDR:     addr_d = reg_wr_data;
                     REG_STATUS: begin
                        if (reg_wr_data[STS_TIMEOUT]) tmo_err_d  = 1'b0;
                        if (reg_wr_data[STS_ADDR])    addr_err_d = 1'b0;
`ifdef LPM_WRITE_VERIFY_EN
                        if (reg_wr_data[STS_VERIFY])  vm_err_d   = 1'b0;
`endif
                     end
                     REG_CMD: begin
                        if (addr_q >= 32'(LUT_DEPTH)) begin
                           addr_err_d = 1'b1;
                        end else if (reg_wr_data[CMD_WR]) begin
                           wr_req_d  = 1'b1;
                           wr_addr_d = addr_q[LUT_DEPTH_BITS-1:0];
                           wr_ip_d   = ip_q;
                           wr_mask_d = mask_q;
                           wr_nh_d   = nh_q;
                           wr_oq_d   = oq_q;
                           timer_clr = 1'b1;
                           state_d   = ST_WR_WAIT;
                           reg_ack_d = 1'b0;
                        end else if (reg_wr_data[CMD_RD]) begin
                           rd_req_d  = 1'b1;
                           rd_addr_d = addr_q[LUT_DEPTH_BITS-1:0];
                           timer_clr = 1'b1;
                           state_d   = ST_RD_WAIT;
                           reg_ack_d = 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_WR_WAIT: begin
            timer_en = 1'b1;
            // An ack in the expiry cycle still counts as success.
            if (lpm_wr_ack && wr_req_q) begin
               wr_req_d   = 1'b0;
               wr_count_d = wr_count_q + 32'd1;
`ifdef LPM_WRITE_VERIFY_EN
               rd_req_d   = 1'b1;
               rd_addr_d  = wr_addr_q;
               timer_clr  = 1'b1;
               state_d    = ST_VRFY_WAIT;
`else
               state_d    = ST_ACK;
               reg_ack_d  = 1'b1;
`endif
            end else if (timer_expired) begin
               wr_req_d  = 1'b0;
               tmo_err_d = 1'b1;
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            timer_en = 1'b1;
            if (lpm_rd_ack && rd_req_q) begin
               rd_req_d  = 1'b0;
               ip_d      = lpm_rd_ip;
               mask_d    = lpm_rd_mask;
               nh_d      = lpm_rd_next_hop_ip;
               oq_d      = lpm_rd_oq;
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
            end else if (timer_expired) begin
               rd_req_d  = 1'b0;
               tmo_err_d = 1'b1;
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
            end
         end
`ifdef LPM_WRITE_VERIFY_EN
         ST_VRFY_WAIT: begin
            timer_en = 1'b1;
            if (lpm_rd_ack && rd_req_q) begin
               rd_req_d = 1'b0;
               if (lpm_rd_ip != wr_ip_q || lpm_rd_mask != wr_mask_q ||
                   lpm_rd_next_hop_ip != wr_nh_q || lpm_rd_oq != wr_oq_q)
                  vm_err_d = 1'b1;
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
            end else if (timer_expired) begin
               rd_req_d  = 1'b0;
               tmo_err_d = 1'b1;
               state_d   = ST_ACK;
               reg_ack_d = 1'b1;
            end
         end
`endif
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ip_q          <= '0;
         mask_q        <= '0;
         nh_q          <= '0;
         oq_q          <= '0;
         addr_q        <= '0;
         tmo_err_q     <= 1'b0;
         addr_err_q    <= 1'b0;
         wr_count_q    <= '0;
         reg_ack_q     <= 1'b0;
         reg_rd_data_q <= '0;
         wr_req_q      <= 1'b0;
         wr_addr_q     <= '0;
         wr_ip_q       <= '0;
         wr_mask_q     <= '0;
         wr_nh_q       <= '0;
         wr_oq_q       <= '0;
         rd_req_q      <= 1'b0;
         rd_addr_q     <= '0;
`ifdef LPM_WRITE_VERIFY_EN
         vm_err_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ip_q          <= ip_d;
         mask_q        <= mask_d;
         nh_q          <= nh_d;
         oq_q          <= oq_d;
         addr_q        <= addr_d;
         tmo_err_q     <= tmo_err_d;
         addr_err_q    <= addr_err_d;
         wr_count_q    <= wr_count_d;
         reg_ack_q     <= reg_ack_d;
         reg_rd_data_q <= reg_rd_data_d;
         wr_req_q      <= wr_req_d;
         wr_addr_q     <= wr_addr_d;
         wr_ip_q       <= wr_ip_d;
         wr_mask_q     <= wr_mask_d;
         wr_nh_q       <= wr_nh_d;
         wr_oq_q       <= wr_oq_d;
         rd_req_q      <= rd_req_d;
         rd_addr_q     <= rd_addr_d;
`ifdef LPM_WRITE_VERIFY_EN
         vm_err_q      <= vm_err_d;
`endif
      end
   end

   assign reg_ack            = reg_ack_q;
   assign reg_rd_data        = reg_rd_data_q;
   assign lpm_wr_req         = wr_req_q;
   assign lpm_wr_addr        = wr_addr_q;
   assign lpm_wr_ip          = wr_ip_q;
   assign lpm_wr_mask        = wr_mask_q;
   assign lpm_wr_next_hop_ip = wr_nh_q;
   assign lpm_wr_oq          = wr_oq_q;
   assign lpm_rd_req         = rd_req_q;
   assign lpm_rd_addr        = rd_addr_q;

endmodule

// File: doc/lpm_table_reg_ctrl.md
Name: lpm_table_reg_ctrl

Overview:
- Register-side initiator for the LPM route table's read/write ports.
- Presents a small word-addressed host register file of staging, command and status registers.
- Turns host command writes into lpm_wr_req / lpm_rd_req transactions and waits for the table's acks.
- Captures read results back into the staging registers. Sits between the host register bus and the router's LPM lookup block.

Parameters:
- NUM_QUEUES, 5: output-queue bitmap width.
- LUT_DEPTH, 32: route table entries.
- LUT_DEPTH_BITS, log2(LUT_DEPTH): entry address width.
- TIMEOUT_CYCLES, 64: maximum wait for an lpm ack before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- reg_req  in  1  host access strobe, single-cycle
- reg_rd_wr_L  in  1  1=read, 0=write
- reg_addr  in  3  word address
- reg_wr_data  in  32  host write data
- reg_ack  out  1  single-cycle access-complete pulse
- reg_rd_data  out  32  read data, valid with reg_ack
- lpm_wr_req  out  1  write request, level
- lpm_wr_addr  out  LUT_DEPTH_BITS  entry address
- lpm_wr_ip  out  32  match IP
- lpm_wr_mask  out  32  subnet mask, 1=care
- lpm_wr_next_hop_ip  out  32  next hop
- lpm_wr_oq  out  NUM_QUEUES  output queue bitmap
- lpm_wr_ack  in  1  write done pulse
- lpm_rd_req  out  1  read request, level
- lpm_rd_addr  out  LUT_DEPTH_BITS  entry address
- lpm_rd_ip  in  32  returned IP
- lpm_rd_mask  in  32  returned mask
- lpm_rd_next_hop_ip  in  32  returned next hop
- lpm_rd_oq  in  NUM_QUEUES  returned queue bitmap
- lpm_rd_ack  in  1  read data valid pulse

Behaviour:
- Register map (word offsets):
  - 0 IP, 1 MASK, 2 NEXT_HOP, 3 OQ (low NUM_QUEUES bits, rest read 0), 4 ADDR (low LUT_DEPTH_BITS).
  - 5 CMD: write bit0=write entry, bit1=read entry; reads return 0.
  - 6 STATUS: bit1 timeout_err, bit2 verify_mismatch, bit3 addr_err; all sticky, write-1-to-clear.
  - 7 WR_COUNT: 32-bit wrapping count of acked writes; read-only.
- Unmapped bits read 0. Writes to read-only registers are ignored but still acked.
- Reset (all outputs and registers to 0):
  - outputs: reg_ack, reg_rd_data, lpm_wr_req, lpm_rd_req, all lpm_* address/data outputs;
  - registers: staging, STATUS, WR_COUNT, timer;
  - state returns to IDLE.
- FSM states: IDLE, WR_WAIT, RD_WAIT, VRFY_WAIT (macro only), ACK.
- IDLE, reg_req to a non-CMD register:
  - Write or read is performed.
  - reg_ack and reg_rd_data are registered and appear 1 cycle after reg_req.
- IDLE, CMD write:
  - If ADDR >= LUT_DEPTH: set addr_err, no lpm request, go to ACK.
  - Else if bit0=1: drive the lpm_wr_* fields from staging, raise lpm_wr_req, go to WR_WAIT. Bit0 has priority when both bits are set; bit1 is ignored.
  - Else if bit1=1: raise lpm_rd_req with lpm_rd_addr=ADDR, go to RD_WAIT.
  - Else (CMD=0): go to ACK.
- Request handshake:
  - The request stays high until its ack is sampled and drops on the following edge (one cycle of overlap).
  - Address/data outputs are held stable for the whole request.
- WR_WAIT, on lpm_wr_ack: WR_COUNT+1, go to ACK.
- RD_WAIT, on lpm_rd_ack:
  - IP, MASK, NEXT_HOP, OQ load from lpm_rd_*.
  - Go to ACK.
- ACK: reg_ack pulses for 1 cycle; return to IDLE. CMD latency is therefore lpm ack + 1 cycle.
- Timeout:
  - The timer clears on request assertion and counts every wait cycle.
  - When the timer reaches TIMEOUT_CYCLES-1 without an ack: drop the request, set timeout_err, go to ACK.
  - Staging registers and WR_COUNT are unchanged.
- reg_req outside IDLE is ignored. The host must wait for reg_ack.
- An lpm ack arriving while the corresponding request is low is ignored.
- An ack on the same cycle as the timeout is treated as success.
- Reset mid-transaction: the request drops at the next edge; no reg_ack is issued.

Optional Feature:
- Macro: LPM_WRITE_VERIFY_EN.
- Defined:
  - After lpm_wr_ack, WR_WAIT goes to VRFY_WAIT and issues lpm_rd_req to the same address.
  - On lpm_rd_ack, compare all four returned fields to the written values. Any difference sets verify_mismatch.
  - Staging registers are not overwritten. reg_ack follows the verify read. The timeout also applies to VRFY_WAIT.
- Undefined: no VRFY_WAIT state; STATUS bit2 reads 0.

Decomposition:
- Package lpm_reg_pkg holds:
  - register offsets (IP..WR_COUNT);
  - STATUS bit indices;
  - CMD bit indices;
  - FSM state encoding.
- Sub-module lpm_req_timer: loadable up-counter taking TIMEOUT_CYCLES, with clear/enable inputs and an expired output.

Test Plan:
- Write IP=0xC0A80100, MASK=0xFFFFFF00, NEXT_HOP=0x0A000001, OQ=0x04, ADDR=3, CMD=0x1; responder acks after 20 cycles -> lpm_wr_req high with those values for 21 cycles, reg_ack 1 cycle after ack, WR_COUNT=1.
- ADDR=3, CMD=0x2; responder returns 0xC0A80100/0xFFFFFF00/0x0A000001/0x04 -> host reads of offsets 0..3 return those values.
- CMD=0x1, responder never acks -> lpm_wr_req drops after 64 cycles, reg_ack, STATUS=0x2; write STATUS=0x2 -> STATUS=0x0.
- ADDR=40 with LUT_DEPTH=32, CMD=0x1 -> no lpm_wr_req, reg_ack 1 cycle later, STATUS bit3=1, WR_COUNT unchanged.
- reset asserted 5 cycles into WR_WAIT -> lpm_wr_req=0 next cycle, no reg_ack, all registers 0.
- LPM_WRITE_VERIFY_EN, verify read returns NEXT_HOP=0x0A000002 -> lpm_rd_req follows the write ack, STATUS bit2=1, staging NEXT_HOP stays 0x0A000001.
